crm_store: RTL

- Parametrised successor to the fixed 2K x 84 CRAM slice.
- Holds the microcode control store, presents a registered CR word to the EBOX every enabled cycle, and adds a diagnostic load path that assembles a microword from narrow chunks.
- Writes the assembled word with a stored odd-parity bit, reads it back to verify, and checks parity on every normal fetch.
- Sits between the CRA address logic (CRADR) and the microword field decoders.

---
 rtl/crm_store.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/crm_store.sv
// crm_store: microcode control store. Presents a registered CR word to the
// EBOX, keeps a sticky odd-parity error on fetches, and offers a diagnostic
// path that assembles a microword from chunks, writes it with parity and
// reads it back to verify.
module crm_store #(
   parameter int ADDR_W  = 11,
   parameter int WORD_W  = 84,
   parameter int CHUNK_W = 36
) (
   input  logic                eboxClk,
   input  logic                eboxReset,
   input  logic [ADDR_W-1:0]   CRADR,
   input  logic                crEn,
   output logic [WORD_W-1:0]   CR,
   output logic                crParErr,
   input  logic                crParClr,
   input  logic                diagStart,
   input  logic [ADDR_W-1:0]   diagAdr,
   input  logic                diagChunkValid,
   input  logic [CHUNK_W-1:0]  diagChunk,
   output logic                diagBusy,
   output logic                diagDone,
   output logic                diagMismatch
);
   localparam int DEPTH  = 2**ADDR_W;
   localparam int NCHUNK = (WORD_W + CHUNK_W - 1) / CHUNK_W;
   localparam int ASM_W  = NCHUNK * CHUNK_W;
   localparam int CNT_W  = $clog2(NCHUNK + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ASSEMBLE = 3'd1,
      WRITE    = 3'd2,
      READ     = 3'd3,
      CHECK    = 3'd4
   } state_t;

   // Odd parity bit for a data word: data XOR parity must come out as 1.
   function automatic logic odd_par(input logic [WORD_W-1:0] w);
      return ~(^w);
   endfunction

   // True when a stored {parity, data} word has correct odd parity.
   function automatic logic par_ok(input logic [WORD_W:0] w);
      return ^w;
   endfunction

   logic [WORD_W:0]    mem_q [DEPTH];

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  cr_q, cr_d;
   logic               par_err_q, par_err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               mis_q, mis_d;
   logic [ADDR_W-1:0]  adr_q, adr_d;
   logic [ASM_W-1:0]   asm_q, asm_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WORD_W:0]    fetch_word_s;
   logic [WORD_W:0]    chk_word_s;
   logic [WORD_W-1:0]  asm_word_s;
   logic [WORD_W:0]    wr_word_s;
   logic               mem_we_s;
   logic               fetch_s;
   logic               fetch_bad_s;

   // The array read feeds only registers, so both ports behave as synchronous reads.
   assign fetch_word_s = mem_q[CRADR];
   assign chk_word_s   = mem_q[adr_q];
   // The first chunk lands in the top bits; the tail of the last chunk is dropped.
   assign asm_word_s   = asm_q[ASM_W-1 -: WORD_W];
   assign wr_word_s    = {odd_par(asm_word_s), asm_word_s};

   // Next-state logic for the fetch path, parity flag and diagnostic sequencer.
   always_comb begin
      state_d   = state_q;
      cr_d      = cr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      mis_d     = mis_q;
      adr_d     = adr_q;
      asm_d     = asm_q;
      cnt_d     = cnt_q;
      mem_we_s  = 1'b0;

      // EBOX stalls while a diagnostic sequence owns the store.
      fetch_s = (state_q == IDLE) && crEn;
      if (fetch_s) begin
         cr_d        = fetch_word_s[WORD_W-1:0];
         fetch_bad_s = ~par_ok(fetch_word_s);
      end else begin
         fetch_bad_s = 1'b0;
      end

      // A new error takes priority over a clear in the same cycle.
      if (fetch_bad_s) begin
         par_err_d = 1'b1;
      end else if (crParClr) begin
         par_err_d = 1'b0;
      end else begin
         par_err_d = par_err_q;
      end

      case (state_q)
         IDLE: begin
            if (diagStart) begin
               state_d = ASSEMBLE;
               adr_d   = diagAdr;
               cnt_d   = {CNT_W{1'b0}};
               mis_d   = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ASSEMBLE: begin
            if (diagChunkValid) begin
               asm_d = (asm_q << CHUNK_W) | ASM_W'(diagChunk);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                  state_d = WRITE;
               end else begin
                  state_d = ASSEMBLE;
               end
            end else begin
               state_d = ASSEMBLE;
            end
         end
         WRITE: begin
            mem_we_s = 1'b1;
            state_d  = READ;
         end
         READ: begin
            // Readback and compare share this edge so the verdict is ready with diagDone.
            mis_d   = (chk_word_s != wr_word_s);
            done_d  = 1'b1;
            state_d = CHECK;
         end
         CHECK: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; memory contents are deliberately not reset.
   always_ff @(posedge eboxClk or posedge eboxReset) begin
      if (eboxReset) begin
         state_q   <= IDLE;
         cr_q      <= {WORD_W{1'b0}};
         par_err_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mis_q     <= 1'b0;
         adr_q     <= {ADDR_W{1'b0}};
         asm_q     <= {ASM_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cr_q      <= cr_d;
         par_err_q <= par_err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         mis_q     <= mis_d;
         adr_q     <= adr_d;
         asm_q     <= asm_d;
         cnt_q     <= cnt_d;
      end
   end

   // Control store write port, used only by the diagnostic WRITE step.
   always_ff @(posedge eboxClk) begin
      if (mem_we_s) begin
         mem_q[adr_q] <= wr_word_s;
      end
   end

   assign CR           = cr_q;
   assign crParErr     = par_err_q;
   assign diagBusy     = busy_q;
   assign diagDone     = done_q;
   assign diagMismatch = mis_q;

endmodule
